// File: rtl/intpol2_sched_pkg.sv
// Shared definitions for the interpolator job scheduler: FSM encoding,
// core status bit positions and descriptor field offsets.
package intpol2_sched_pkg;

  localparam int unsigned CFG_W = 128;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CFG   = 3'd1,
    S_START = 3'd2,
    S_RUN   = 3'd3,
    S_DONE  = 3'd4,
    S_GAP   = 3'd5
  } sched_state_t;

  localparam int unsigned DONE_B  = 0;
  localparam int unsigned BUSY_B  = 1;
  localparam int unsigned EMPTY_B = 2;
  localparam int unsigned AFULL_B = 3;

  localparam int unsigned BYPASS_B = 0;
  localparam int unsigned IX_LSB   = 32;
  localparam int unsigned IX2_LSB  = 64;
  localparam int unsigned ILEN_LSB = 96;

  function automatic logic [CFG_W-1:0] pack_cfg(input logic bypass,
                                                 input logic [31:0] ix,
                                                 input logic [31:0] ix2,
                                                 input logic [31:0] ilen);
    logic [CFG_W-1:0] w;
    w = '0;
    w[BYPASS_B]             = bypass;
    w[IX_LSB   +: 32]       = ix;
    w[IX2_LSB  +: 32]       = ix2;
    w[ILEN_LSB +: 32]       = ilen;
    return w;
  endfunction

  function automatic logic is_stall(input logic [7:0] status);
    return status[EMPTY_B] || status[AFULL_B];
  endfunction

endpackage

// File: rtl/intpol2_job_fifo.sv
// Synchronous descriptor FIFO with flush; flush wins over push and pop.
module intpol2_job_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 128
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Full is judged before any same-cycle pop, so a full queue never accepts.
  assign full    = (level == LW'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push && !rstn) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/intpol2_job_scheduler.sv
// Walks the interpolator core through queued descriptors: config, start
// pulse, wait for done, count completion, with a stall watchdog.
module intpol2_job_scheduler
  import intpol2_sched_pkg::*;
#(
  parameter int unsigned JOB_DEPTH  = 4,
  parameter int unsigned GAP_CYCLES = 2,
  parameter int unsigned STALL_MAX  = 1024,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        enable,
  input  logic                        flush,
  input  logic                        job_valid,
  output logic                        job_ready,
  input  logic [127:0]                job_cfg,
  input  logic [7:0]                  core_status,
  output logic                        core_start,
  output logic [127:0]                core_config_reg,
  output logic                        sched_busy,
  output logic                        job_done_pulse,
  output logic [CNT_WIDTH-1:0]        jobs_completed,
  output logic [CNT_WIDTH-1:0]        stall_cycles,
  output logic                        stall_timeout,
  output logic [$clog2(JOB_DEPTH):0]  q_level
);

  localparam int unsigned GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam int unsigned RW = $clog2(STALL_MAX + 1);

  sched_state_t   state;
  logic           start_q;
  logic           done_q;
  logic           done_rise;
  logic           stall;
  logic           launch;
  logic           fifo_full;
  logic           fifo_empty;
  logic [127:0]   head;
  logic [GW-1:0]  gap_cnt;
  logic [RW-1:0]  run_cnt;
  logic           unused_status;

  assign done_rise     = core_status[DONE_B] && !done_q;
  assign stall         = is_stall(core_status);
  assign launch        = (state == S_IDLE) && enable && !fifo_empty && !flush;
  assign job_ready     = !fifo_full && !flush && !rstn;
  assign core_start    = start_q && !rstn;
  assign sched_busy    = (state != S_IDLE) || !fifo_empty;
  assign unused_status = ^{core_status[7:4], core_status[BUSY_B]};

  intpol2_job_fifo #(
    .DEPTH (JOB_DEPTH),
    .WIDTH (CFG_W)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (job_valid && job_ready),
    .pop   (launch),
    .flush (flush),
    .din   (job_cfg),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (q_level)
  );

  always_ff @(posedge clk) begin
    if (rstn) begin
      state           <= S_IDLE;
      start_q         <= 1'b0;
      done_q          <= 1'b0;
      core_config_reg <= '0;
      job_done_pulse  <= 1'b0;
      jobs_completed  <= '0;
      stall_cycles    <= '0;
      stall_timeout   <= 1'b0;
      gap_cnt         <= '0;
      run_cnt         <= '0;
    end else begin
      done_q         <= core_status[DONE_B];
      start_q        <= 1'b0;
      job_done_pulse <= 1'b0;
      case (state)
        S_IDLE: begin
          if (launch) begin
            core_config_reg <= head;
            state           <= S_CFG;
          end
        end
        S_CFG: begin
          // Watchdog is cleared as the start pulse is issued so START reads clean.
          start_q       <= 1'b1;
          stall_cycles  <= '0;
          stall_timeout <= 1'b0;
          run_cnt       <= '0;
          state         <= S_START;
        end
        S_START: begin
          state <= S_RUN;
        end
        S_RUN: begin
          if (stall) begin
            if (stall_cycles != '1) begin
              stall_cycles <= stall_cycles + 1'b1;
            end
            if (run_cnt != RW'(STALL_MAX)) begin
              run_cnt <= run_cnt + 1'b1;
            end
            if (run_cnt >= RW'(STALL_MAX - 1)) begin
              stall_timeout <= 1'b1;
            end
          end else begin
            run_cnt <= '0;
          end
          if (done_rise) begin
            job_done_pulse <= 1'b1;
            jobs_completed <= jobs_completed + 1'b1;
            state          <= S_DONE;
          end
        end
        S_DONE: begin
          gap_cnt <= '0;
          state   <= S_GAP;
        end
        S_GAP: begin
          if (gap_cnt == GW'(GAP_CYCLES - 1)) begin
            state <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/intpol2_job_scheduler.md
Name: intpol2_job_scheduler

Overview:
- Sequences the IQ quadratic interpolator core through a queue of job descriptors. Each descriptor is one 128-bit configuration word (bypass, iX, iX2, ilen).
- Per job: latches the descriptor, drives the core config word stable, pulses start, waits for done, then counts and reports completion.
- Monitors the core stall flags (stop_empty, stop_Afull) with a watchdog.
- Sits between the host register interface and the interpolator core.

Parameters:
- JOB_DEPTH, 4, descriptor queue depth; power of 2, at least 2.
- GAP_CYCLES, 2, minimum idle cycles between done and the next start; at least 1.
- STALL_MAX, 1024, consecutive stall cycles in RUN before stall_timeout is set.
- CNT_WIDTH, 16, width of jobs_completed and stall_cycles.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rstn  in  1  reset; synchronous, active-high (1 = reset).
- enable  in  1  when 0, no new job is launched; an active job still finishes.
- flush  in  1  empties the queue; the active job is unaffected.
- job_valid  in  1  descriptor push request.
- job_ready  out  1  queue can accept a push (not full and flush low).
- job_cfg  in  128  descriptor: [0] bypass, [63:32] iX, [95:64] iX2, [127:96] ilen.
- core_status  in  8  core status: [0] done, [1] busy, [2] stop_empty, [3] stop_Afull.
- core_start  out  1  one-cycle start pulse to the core.
- core_config_reg  out  128  configuration to the core; held constant from CFG until the next CFG.
- sched_busy  out  1  state is not IDLE, or the queue is non-empty.
- job_done_pulse  out  1  one-cycle pulse per completed job.
- jobs_completed  out  CNT_WIDTH  free-running completion count; wraps.
- stall_cycles  out  CNT_WIDTH  stall count for the current job; saturates at all-ones.
- stall_timeout  out  1  sticky watchdog flag; cleared at the next START.
- q_level  out  $clog2(JOB_DEPTH)+1  current queue occupancy.

Behaviour:
- Reset (rstn=1):
  - Queue emptied; state IDLE.
  - All outputs 0, including core_config_reg and all counters.
  - Reset mid-run abandons the job with no done pulse; core_start is guaranteed 0 in the reset cycle.
- Queue:
  - Push when job_valid && job_ready.
  - job_ready = !full && !flush. A push into a full queue is refused even if a pop happens in the same cycle.
  - flush=1: occupancy is 0 next cycle and any same-cycle push is dropped. Flush has priority over pop, so no pop occurs that cycle.
- FSM states: IDLE, CFG, START, RUN, DONE, GAP.
- Done detection: done_rise = core_status[0] && !done_q. done_q is registered and reset to 0.
- IDLE -> CFG when enable && queue non-empty && !flush. Pops the head into core_config_reg that cycle.
- CFG: one cycle so the config is stable before start. Goes to START.
- START: core_start=1 for exactly one cycle. Clears stall_cycles and stall_timeout. Goes to RUN.
- RUN: waits for done_rise, with no timeout on done.
  - Every cycle with core_status[2] or core_status[3] increments stall_cycles (saturating).
  - When the consecutive-stall run counter reaches STALL_MAX, stall_timeout is set. The counter resets on any non-stall cycle.
  - A done_rise in the same cycle as a stall is still accepted.
- DONE: one cycle. job_done_pulse=1 and jobs_completed += 1 (wraps at 2^CNT_WIDTH).
- GAP: lasts GAP_CYCLES cycles, then IDLE.
- Launch latency: with the queue non-empty and in IDLE, core_start rises 2 cycles after the pop cycle (pop in IDLE, CFG, then START).
- Minimum spacing from a done_rise cycle to the next core_start is GAP_CYCLES+4 cycles: DONE, GAP×GAP_CYCLES, IDLE, CFG, START.
- Bypass descriptors are sequenced identically; the core signals done in bypass too.
- done_rise seen outside RUN is ignored, with no count.
- enable falling during RUN: the job completes; the scheduler then parks in IDLE.

Decomposition:
- Package intpol2_sched_pkg holds:
  - FSM state encoding (3-bit).
  - core_status bit indices (DONE_B=0, BUSY_B=1, EMPTY_B=2, AFULL_B=3).
  - job_cfg field offsets (BYPASS_B=0, IX_LSB=32, IX2_LSB=64, ILEN_LSB=96).
- Sub-module intpol2_job_fifo: synchronous JOB_DEPTH×128 FIFO with push/pop/flush and level output; same reset as the top.
- FSM, counters and watchdog live in the top level.

Test Plan:
- Single job: push cfg with iX=0x40000000, ilen=8, enable=1; core model raises done 20 cycles after start. Expect:
  - core_start exactly 2 cycles after the pop.
  - core_config_reg equal to the pushed word from CFG onward.
  - One job_done_pulse; jobs_completed=1.
- Back-to-back: push 4 jobs (queue full). Expect job_ready=0 with q_level=4, 4 starts in order, done→next start spacing of 6 cycles with GAP_CYCLES=2, and jobs_completed=4.
- Watchdog: hold stop_empty=1 for 1024 cycles in RUN, then done. Expect stall_timeout=1 at cycle 1024 and staying set, stall_cycles=1024, and the flag cleared at the next START.
- Flush: with 3 jobs queued and 1 running, assert flush together with job_valid for 1 cycle. Expect q_level=0, the push dropped, the running job completing, and no further start.
- Reset mid-RUN: assert rstn=1 for 1 cycle while in RUN. Expect all outputs 0 and no job_done_pulse; a later push launches normally.
- Enable gating and spurious done: with enable=0 and 2 jobs queued, expect no start. Pulse done while in IDLE and expect no count. Set enable=1 and expect 2 jobs run.
